// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle bit indices, widths and the
// MEM-stage FSM state type.
package pipeline_pkg;

  localparam int unsigned SIG_W  = 11;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned SIG_REG_WRITE  = 0;
  localparam int unsigned SIG_MEM_TO_REG = 1;
  localparam int unsigned SIG_MEM_READ   = 2;
  localparam int unsigned SIG_MEM_WRITE  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus. master = pipeline MEM stage, slave = memory.
interface memory_stage_if;
  import pipeline_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_stage_fsm.sv
// MEM-stage access sequencer: owns the IDLE/WAIT state, the registered
// dmem_* request outputs and (with MEM_TIMEOUT_EN) the timeout counter.
module memory_stage_fsm
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output state_e            state,
  output logic              timeout_hit,
  memory_stage_if.master    dmem
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Limit reached in a WAIT cycle with no ack; a same-cycle ack wins
  always_comb begin
    timeout_hit = (state_q == WAIT) && !dmem.dmem_ack && (cnt_q == 8'(TIMEOUT - 1));
  end
`else
  // No timeout: WAIT lasts until ack
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Next-state and request register updates
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = addr;
          wdata_d = wdata;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (dmem.dmem_ack || timeout_hit) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign state           = state_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: passes non-memory instructions through combinationally,
// sequences loads/stores over the dmem req/ack bus, stalls upstream while an
// access is outstanding and feeds the MEM/WB latch a bubble meanwhile.
// Optional feature macro: MEM_TIMEOUT_EN (abandon access after TIMEOUT cycles).
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [SIG_W-1:0]  ex_signals,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_stall,
  output logic [RD_W-1:0]   mem_rd,
  output logic [SIG_W-1:0]  mem_signals,
  output logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic              mem_err,
  memory_stage_if.master    dmem
);

  state_e state;
  logic   timeout_hit;
  logic   mem_op, is_store, aligned;

  // Instruction decode; read+write together counts as a store
  always_comb begin
    mem_op   = ex_valid && (ex_signals[SIG_MEM_READ] || ex_signals[SIG_MEM_WRITE]);
    is_store = ex_signals[SIG_MEM_WRITE];
    aligned  = (ex_alu_result[1:0] == 2'b00);
  end

  memory_stage_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .start       (mem_op && aligned),
    .is_store    (is_store),
    .addr        (ex_alu_result),
    .wdata       (ex_store_data),
    .state       (state),
    .timeout_hit (timeout_hit),
    .dmem        (dmem)
  );

  // Output mux toward MEM/WB: pass-through, bubble, or completed access
  always_comb begin
    mem_stall      = 1'b0;
    mem_err        = 1'b0;
    mem_rd         = ex_rd;
    mem_signals    = ex_valid ? ex_signals : '0;
    mem_read_data  = '0;
    mem_alu_result = ex_alu_result;
    if (rst) begin
      mem_rd         = '0;
      mem_signals    = '0;
      mem_alu_result = '0;
    end else if (state == WAIT) begin
      if (dmem.dmem_ack) begin
        mem_read_data = is_store ? '0 : dmem.dmem_rdata;
      end else begin
        mem_rd         = '0;
        mem_signals    = '0;
        mem_alu_result = '0;
        if (timeout_hit) begin
          mem_err = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
    end else if (mem_op) begin
      mem_rd         = '0;
      mem_signals    = '0;
      mem_alu_result = '0;
      if (aligned) begin
        mem_stall = 1'b1;
      end else begin
        mem_err = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;
  import pipeline_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [RD_W-1:0]   ex_rd;
  logic [SIG_W-1:0]  ex_signals;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              mem_stall;
  logic [RD_W-1:0]   mem_rd;
  logic [SIG_W-1:0]  mem_signals;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] mem_alu_result;
  logic              mem_err;

  int checks = 0;
  int errors = 0;

  memory_stage_if dmem ();

  memory_stage #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_signals     (ex_signals),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .mem_stall      (mem_stall),
    .mem_rd         (mem_rd),
    .mem_signals    (mem_signals),
    .mem_read_data  (mem_read_data),
    .mem_alu_result (mem_alu_result),
    .mem_err        (mem_err),
    .dmem           (dmem.master)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs sampled 2 ns later, well away from either clock edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_ex(input logic v, input logic [3:0] rd, input logic [10:0] sig,
                          input logic [31:0] alu, input logic [31:0] sd);
    ex_valid = v; ex_rd = rd; ex_signals = sig; ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_ex(1'b1, 4'h3, 11'h001, 32'h55, 32'h66);
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    next_cycle(); next_cycle(); settle();
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", mem_stall); end
    checks++; if (mem_signals !== 11'h0) begin errors++; $display("FAIL reset_signals got %h exp 000", mem_signals); end
    checks++; if (mem_alu_result !== 32'h0) begin errors++; $display("FAIL reset_alu got %h exp 0", mem_alu_result); end
    checks++; if (mem_rd !== 4'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", mem_rd); end
    checks++; if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata} !== 66'h0)
      begin errors++; $display("FAIL reset_dmem got req=%b we=%b addr=%h wdata=%h exp all 0",
        dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", mem_err); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_alu_op();
    drive_ex(1'b1, 4'h7, 11'h001, 32'h1234, 32'h0);
    dmem.dmem_ack = 1'b1;  // ack must be ignored in IDLE
    settle();
    checks++; if (mem_alu_result !== 32'h1234) begin errors++; $display("FAIL alu_result got %h exp 00001234", mem_alu_result); end
    checks++; if (mem_signals !== 11'h001) begin errors++; $display("FAIL alu_signals got %h exp 001", mem_signals); end
    checks++; if (mem_rd !== 4'h7) begin errors++; $display("FAIL alu_rd got %h exp 7", mem_rd); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", mem_stall); end
    checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL alu_rdata got %h exp 0", mem_read_data); end
    next_cycle(); settle();
    checks++; if (dmem.dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req got %b exp 0", dmem.dmem_req); end
    // Invalid slot: signals forced to zero, no stall
    ex_valid = 1'b0; ex_signals = 11'h00C;
    settle();
    checks++; if (mem_signals !== 11'h0 || mem_stall !== 1'b0) begin errors++;
      $display("FAIL invalid_slot got sig=%h stall=%b exp sig=000 stall=0", mem_signals, mem_stall); end
    dmem.dmem_ack = 1'b0;
    next_cycle();
  endtask

  task automatic test_load_delay();
    int stalls = 0;
    drive_ex(1'b1, 4'h5, 11'h007, 32'h100, 32'h0);
    dmem.dmem_rdata = 32'hDEADBEEF;
    settle();
    checks++; if (mem_stall !== 1'b1 || mem_signals !== 11'h0 || dmem.dmem_req !== 1'b0) begin errors++;
      $display("FAIL load_issue got stall=%b sig=%h req=%b exp 1 000 0", mem_stall, mem_signals, dmem.dmem_req); end
    if (mem_stall) stalls++;
    next_cycle(); settle();
    checks++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 32'h100 || dmem.dmem_we !== 1'b0) begin errors++;
      $display("FAIL load_req got req=%b addr=%h we=%b exp 1 00000100 0", dmem.dmem_req, dmem.dmem_addr, dmem.dmem_we); end
    if (mem_stall) stalls++;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      if (mem_stall) stalls++;
    end
    next_cycle();
    dmem.dmem_ack = 1'b1;
    settle();
    checks++; if (stalls !== 4) begin errors++; $display("FAIL load_stall_cycles got %0d exp 4", stalls); end
    checks++; if (mem_stall !== 1'b0 || mem_read_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL load_ack got stall=%b rdata=%h exp 0 deadbeef", mem_stall, mem_read_data); end
    checks++; if (mem_signals !== 11'h007 || mem_rd !== 4'h5 || mem_alu_result !== 32'h100) begin errors++;
      $display("FAIL load_present got sig=%h rd=%h alu=%h exp 007 5 00000100", mem_signals, mem_rd, mem_alu_result); end
    next_cycle();
    dmem.dmem_ack = 1'b0;
    drive_ex(1'b1, 4'h1, 11'h001, 32'h8, 32'h0);
    settle();
    checks++; if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++;
      $display("FAIL load_done got req=%b stall=%b exp 0 0", dmem.dmem_req, mem_stall); end
    next_cycle();
  endtask

  task automatic test_store_immediate();
    drive_ex(1'b1, 4'h0, 11'h008, 32'h40, 32'hA5A5A5A5);
    dmem.dmem_rdata = 32'h12345678;
    settle();
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL store_issue_stall got %b exp 1", mem_stall); end
    next_cycle();
    dmem.dmem_ack = 1'b1;
    settle();
    checks++; if (dmem.dmem_we !== 1'b1 || dmem.dmem_wdata !== 32'hA5A5A5A5 || dmem.dmem_addr !== 32'h40) begin errors++;
      $display("FAIL store_req got we=%b wdata=%h addr=%h exp 1 a5a5a5a5 00000040", dmem.dmem_we, dmem.dmem_wdata, dmem.dmem_addr); end
    checks++; if (mem_stall !== 1'b0 || mem_read_data !== 32'h0 || mem_signals !== 11'h008) begin errors++;
      $display("FAIL store_ack got stall=%b rdata=%h sig=%h exp 0 0 008", mem_stall, mem_read_data, mem_signals); end
    next_cycle();
    dmem.dmem_ack = 1'b0;
    ex_valid = 1'b0;
    settle();
    checks++; if (dmem.dmem_req !== 1'b0) begin errors++; $display("FAIL store_done_req got %b exp 0", dmem.dmem_req); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    // Read+write both set: treated as a store
    drive_ex(1'b1, 4'h2, 11'h00C, 32'h80, 32'h11);
    next_cycle();
    dmem.dmem_ack = 1'b1;
    settle();
    checks++; if (dmem.dmem_we !== 1'b1 || mem_read_data !== 32'h0) begin errors++;
      $display("FAIL rw_as_store got we=%b rdata=%h exp 1 0", dmem.dmem_we, mem_read_data); end
    next_cycle();
    dmem.dmem_ack = 1'b0;
    drive_ex(1'b1, 4'h3, 11'h007, 32'h84, 32'h0);
    settle();
    checks++; if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b1) begin errors++;
      $display("FAIL b2b_idle got req=%b stall=%b exp 0 1", dmem.dmem_req, mem_stall); end
    next_cycle(); settle();
    checks++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 32'h84 || dmem.dmem_we !== 1'b0) begin errors++;
      $display("FAIL b2b_req got req=%b addr=%h we=%b exp 1 00000084 0", dmem.dmem_req, dmem.dmem_addr, dmem.dmem_we); end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hCAFE0001;
    settle();
    checks++; if (mem_read_data !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_rdata got %h exp cafe0001", mem_read_data); end
    next_cycle();
    dmem.dmem_ack = 1'b0; ex_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_misaligned();
    drive_ex(1'b1, 4'h4, 11'h007, 32'h102, 32'h0);
    settle();
    checks++; if (mem_err !== 1'b1 || mem_stall !== 1'b0) begin errors++;
      $display("FAIL misalign_err got err=%b stall=%b exp 1 0", mem_err, mem_stall); end
    checks++; if (mem_signals !== 11'h0 || mem_rd !== 4'h0 || mem_alu_result !== 32'h0) begin errors++;
      $display("FAIL misalign_bubble got sig=%h rd=%h alu=%h exp 0 0 0", mem_signals, mem_rd, mem_alu_result); end
    next_cycle();
    drive_ex(1'b1, 4'h1, 11'h001, 32'h9, 32'h0);
    settle();
    checks++; if (dmem.dmem_req !== 1'b0 || mem_err !== 1'b0) begin errors++;
      $display("FAIL misalign_after got req=%b err=%b exp 0 0", dmem.dmem_req, mem_err); end
    next_cycle();
  endtask

  task automatic test_reset_in_wait();
    drive_ex(1'b1, 4'h6, 11'h007, 32'h300, 32'h0);
    next_cycle();   // WAIT cycle 1
    next_cycle();   // WAIT cycle 2
    rst = 1'b1;
    settle();
    checks++; if (mem_stall !== 1'b0 || mem_signals !== 11'h0) begin errors++;
      $display("FAIL rst_wait_out got stall=%b sig=%h exp 0 000", mem_stall, mem_signals); end
    next_cycle();
    rst = 1'b0;
    drive_ex(1'b1, 4'h2, 11'h001, 32'hABC, 32'h0);
    settle();
    checks++; if (dmem.dmem_req !== 1'b0 || dmem.dmem_addr !== 32'h0) begin errors++;
      $display("FAIL rst_wait_dmem got req=%b addr=%h exp 0 0", dmem.dmem_req, dmem.dmem_addr); end
    checks++; if (mem_alu_result !== 32'hABC || mem_stall !== 1'b0) begin errors++;
      $display("FAIL rst_wait_idle got alu=%h stall=%b exp 00000abc 0", mem_alu_result, mem_stall); end
    next_cycle();
  endtask

  task automatic test_timeout();
    drive_ex(1'b1, 4'h8, 11'h007, 32'h200, 32'h0);
    next_cycle();
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      settle();
      checks++; if (mem_stall !== 1'b1 || mem_err !== 1'b0) begin errors++;
        $display("FAIL timeout_wait%0d got stall=%b err=%b exp 1 0", i, mem_stall, mem_err); end
      next_cycle();
    end
    settle();
    checks++; if (mem_err !== 1'b1 || mem_stall !== 1'b0 || mem_signals !== 11'h0) begin errors++;
      $display("FAIL timeout_hit got err=%b stall=%b sig=%h exp 1 0 000", mem_err, mem_stall, mem_signals); end
    next_cycle();
    drive_ex(1'b1, 4'h1, 11'h001, 32'h44, 32'h0);
    settle();
    checks++; if (dmem.dmem_req !== 1'b0 || mem_err !== 1'b0 || mem_alu_result !== 32'h44) begin errors++;
      $display("FAIL timeout_resume got req=%b err=%b alu=%h exp 0 0 00000044", dmem.dmem_req, mem_err, mem_alu_result); end
`else
    for (int i = 1; i <= 6; i++) begin
      settle();
      checks++; if (mem_stall !== 1'b1 || mem_err !== 1'b0 || dmem.dmem_req !== 1'b1) begin errors++;
        $display("FAIL nolimit_wait%0d got stall=%b err=%b req=%b exp 1 0 1", i, mem_stall, mem_err, dmem.dmem_req); end
      next_cycle();
    end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h0BADF00D;
    settle();
    checks++; if (mem_read_data !== 32'h0BADF00D || mem_stall !== 1'b0) begin errors++;
      $display("FAIL nolimit_ack got rdata=%h stall=%b exp 0badf00d 0", mem_read_data, mem_stall); end
    next_cycle();
    dmem.dmem_ack = 1'b0;
`endif
    ex_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_delay();
    test_store_immediate();
    test_back_to_back();
    test_misaligned();
    test_reset_in_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
